// File: rtl/gerador_tempo_termino.sv
// Time base and deadline monitor driving the Tempo/valido/Termino adder interface.
// Generates Tempo, captures the returned deadline and pulses expirado when it is reached.
//
// state      | meaning
// s_idle     | no deadline monitored, valido high
// s_captura  | valido low for one cycle, Termino sampled into prazo on exit
// s_espera   | monitoring prazo against Tempo
// s_expirado | one-cycle expiry pulse, then back to idle
module gerador_tempo_termino #(
  parameter int TICK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  input  logic       cancelar,
  input  logic [6:0] Termino,
  output logic [6:0] Tempo,
  output logic       valido,
  output logic       ativo,
  output logic       expirado,
  output logic [6:0] restante
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    s_idle,
    s_captura,
    s_espera,
    s_expirado
  } estado_t;

  estado_t       estado, estado_prox;
  logic [DW-1:0] div;
  logic          tick;
  logic [6:0]    prazo;

  assign tick = (div == DIV_MAX);

  // Free-running time base; only reset ever stops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      Tempo <= '0;
    end else if (tick) begin
      div   <= '0;
      Tempo <= Tempo + 7'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= s_idle;
      prazo  <= '0;
    end else begin
      estado <= estado_prox;
      if (estado == s_captura) prazo <= Termino;
    end
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      s_idle:     if (inicio && !cancelar) estado_prox = s_captura;
      s_captura:  estado_prox = cancelar ? s_idle : s_espera;
      s_espera: begin
        if (cancelar)              estado_prox = s_idle;
        else if (inicio)           estado_prox = s_captura;
        else if (Tempo == prazo)   estado_prox = s_expirado;
      end
      s_expirado: estado_prox = s_idle;
      default:    estado_prox = s_idle;
    endcase
  end

  // Moore decode; restante is only meaningful once prazo holds the new deadline.
  always_comb begin
    valido   = 1'b1;
    ativo    = 1'b0;
    expirado = 1'b0;
    restante = '0;
    case (estado)
      s_captura: begin
        valido = 1'b0;
        ativo  = 1'b1;
      end
      s_espera: begin
        ativo    = 1'b1;
        restante = prazo - Tempo;
      end
      s_expirado: expirado = 1'b1;
      default: ;
    endcase
  end

endmodule
